// File: rtl/sat_accum_pkg.sv
// Shared types and width-dependent saturation limits for the streaming accumulator.
// Used by sat_add_cell and sat_accum_stream.
package sat_accum_pkg;

   localparam int SAT_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   // Limits are returned at SAT_W bits; callers keep the low w bits.
   function automatic logic [SAT_W-1:0] sat_max(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [SAT_W-1:0] sat_min(input int w);
      return 64'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/sat_add_cell.sv
// Combinational signed saturating adder; clamped flags a step that hit MAX or MIN.
module sat_add_cell
   import sat_accum_pkg::*;
#(
   parameter int BITWIDTH = 32
) (
   input  logic [BITWIDTH-1:0] a,
   input  logic [BITWIDTH-1:0] b,
   output logic [BITWIDTH-1:0] sum,
   output logic                clamped
);

   localparam logic [SAT_W-1:0] MAX_L = sat_max(BITWIDTH);
   localparam logic [SAT_W-1:0] MIN_L = sat_min(BITWIDTH);

   logic [BITWIDTH:0] s;
   logic              pos_ovf;
   logic              neg_ovf;

   assign s = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};

   // Top two bits of the widened sum disagree only on overflow.
   assign pos_ovf = ~s[BITWIDTH] & s[BITWIDTH-1];
   assign neg_ovf = s[BITWIDTH] & ~s[BITWIDTH-1];

   always_comb begin
      sum     = s[BITWIDTH-1:0];
      clamped = 1'b0;
      if (pos_ovf) begin
         sum     = MAX_L[BITWIDTH-1:0];
         clamped = 1'b1;
      end else if (neg_ovf) begin
         sum     = MIN_L[BITWIDTH-1:0];
         clamped = 1'b1;
      end
   end

endmodule

// File: rtl/sat_accum_stream.sv
// Back-pressured saturating frame reduction: one capped sum, count and sat flag per frame.
// Optional sticky saturation flag built when SAT_ACCUM_SAT_FLAG_EN is defined.
module sat_accum_stream
   import sat_accum_pkg::*;
#(
   parameter int BITWIDTH = 32,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BITWIDTH-1:0] in_data,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BITWIDTH-1:0] out_data,
   output logic [CNT_W-1:0]    out_count,
   output logic                out_sat
);

   state_t              state;
   logic [BITWIDTH-1:0] acc;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_next;
   logic [BITWIDTH-1:0] step_sum;
   logic                step_clamp;
   logic                accept;

   sat_add_cell #(
      .BITWIDTH(BITWIDTH)
   ) u_add (
      .a      (acc),
      .b      (in_data),
      .sum    (step_sum),
      .clamped(step_clamp)
   );

   assign accept   = in_valid & in_ready;
   assign cnt_next = (&cnt) ? cnt : cnt + 1'b1;

`ifdef SAT_ACCUM_SAT_FLAG_EN
   logic sticky;
   logic sticky_next;

   assign sticky_next = sticky | step_clamp;
`else
   logic unused_clamp;

   assign unused_clamp = step_clamp;
   assign out_sat      = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
`ifdef SAT_ACCUM_SAT_FLAG_EN
         sticky    <= 1'b0;
         out_sat   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  if (in_last) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_data  <= step_sum;
                     out_count <= cnt_next;
`ifdef SAT_ACCUM_SAT_FLAG_EN
                     out_sat   <= sticky_next;
`endif
                  end else begin
                     state <= ACCUM;
                     acc   <= step_sum;
                     cnt   <= cnt_next;
`ifdef SAT_ACCUM_SAT_FLAG_EN
                     sticky <= sticky_next;
`endif
                  end
               end
            end
            HOLD: begin
               // Result stays put until the consumer takes it.
               if (out_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
`ifdef SAT_ACCUM_SAT_FLAG_EN
                  sticky    <= 1'b0;
`endif
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sat_accum_stream.sv
// Directed scoreboard bench for sat_accum_stream at BITWIDTH=8, CNT_W=4.
// Expected out_sat follows SAT_ACCUM_SAT_FLAG_EN when the build defines it.
module tb_sat_accum_stream;

   localparam int BW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [BW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [BW-1:0] out_data;
   logic [CW-1:0] out_count;
   logic          out_sat;

   typedef struct {
      int data;
      int count;
      int sat;
   } res_t;

   res_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_acc = 0;
   int   m_cnt = 0;
   int   m_sat = 0;

   sat_accum_stream #(
      .BITWIDTH(BW),
      .CNT_W   (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_count(out_count),
      .out_sat  (out_sat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_sat(input int s);
`ifdef SAT_ACCUM_SAT_FLAG_EN
      return s;
`else
      return 0 * s;
`endif
   endfunction

   // Drive one beat from a negedge; returns at the negedge after acceptance.
   task automatic send(input int d, input bit last);
      int t = 0;
      in_valid = 1'b1;
      in_data  = d[BW-1:0];
      in_last  = last;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $error("FAIL send_timeout observed=%0d expected=%0d", 0, 1);
      end else begin
         @(posedge clk);
         m_acc = m_acc + d;
         if (m_acc > 127) begin
            m_acc = 127;
            m_sat = 1;
         end else if (m_acc < -128) begin
            m_acc = -128;
            m_sat = 1;
         end
         if (m_cnt < 15) m_cnt++;
         if (last) begin
            sb.push_back('{data: m_acc, count: m_cnt, sat: exp_sat(m_sat)});
            m_acc = 0;
            m_cnt = 0;
            m_sat = 0;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic get_result(input string tag);
      res_t e;
      int   t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_valid"}, 32'(out_valid), 1);
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL %s_sb_empty observed=%0d expected=%0d", tag, 0, 1);
      end else begin
         e = sb.pop_front();
         check({tag, "_data"}, $signed(out_data), e.data);
         check({tag, "_count"}, 32'(out_count), e.count);
         check({tag, "_sat"}, 32'(out_sat), e.sat);
      end
      if (out_ready) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", $signed(out_data), 0);
      check("rst_out_count", 32'(out_count), 0);
      check("rst_out_sat", 32'(out_sat), 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame with latency check right after the last beat.
      send(10, 0);
      send(20, 0);
      send(-5, 1);
      idle();
      check("f1_latency", 32'(out_valid), 1);
      check("f1_in_ready_hold", 32'(in_ready), 0);
      get_result("f1");
      check("f1_released", 32'(out_valid), 0);

      // Clamp high, then recover from the clamped value.
      send(100, 0);
      send(100, 0);
      send(-50, 1);
      idle();
      get_result("f2");

      send(-100, 0);
      send(-100, 1);
      idle();
      get_result("f3");

      // Counter saturation with back-to-back beats.
      for (int i = 0; i < 20; i++) send(1, i == 19);
      idle();
      get_result("f4");

      // Back-pressure: result held, new sample blocked until handshake.
      out_ready = 1'b0;
      send(-7, 0);
      send(3, 1);
      in_valid = 1'b1;
      in_data  = 8'd7;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("hold_in_ready", 32'(in_ready), 0);
         check("hold_valid", 32'(out_valid), 1);
         check("hold_data", $signed(out_data), -4);
         check("hold_count", 32'(out_count), 2);
         @(negedge clk);
      end
      get_result("f5");
      out_ready = 1'b1;
      send(7, 1);
      idle();
      get_result("f6");
      check("f6_no_dup", 32'(out_valid), 0);

      // Reset mid-frame discards the partial sum.
      send(50, 0);
      send(60, 0);
      idle();
      #2 rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 1);
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_data", $signed(out_data), 0);
      check("mid_rst_count", 32'(out_count), 0);
      m_acc = 0;
      m_cnt = 0;
      m_sat = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(5, 1);
      idle();
      get_result("f7");

      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
